// File: rtl/axi4lite_master_bfm.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out, one held response back.
// Optional watchdog abort is built only when AXI4L_MASTER_TIMEOUT_EN is defined.
module axi4lite_master_bfm #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

    state_t                  r_state;
    logic                    r_cmd_ready, r_write, r_aw_done, r_w_done;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                    r_rsp_valid, r_rsp_write;
    logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_rsp_rdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic [1:0]              r_rsp_resp;

    logic w_accept, w_aw_done, w_w_done;

    // cmd_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept  = cmd_valid & r_cmd_ready;
    assign w_aw_done = r_aw_done | (r_awvalid & m_axi_awready);
    assign w_w_done  = r_w_done  | (r_wvalid  & m_axi_wready);

`ifdef AXI4L_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_timeout;
    logic             w_busy, w_expire;

    assign w_busy      = r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    assign w_expire    = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                         !((r_state == WR_RESP && m_axi_bvalid) || (r_state == RD_DATA && m_axi_rvalid));
    assign rsp_timeout = r_rsp_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign rsp_timeout = 1'b0;
`endif

    // NOTE: every output is a flop updated with <= on one edge, so the slave never sees a combinational path.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            r_cnt         <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_state     <= RESP;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= '0;
                        r_awaddr    <= '0;
                        r_araddr    <= '0;
                        r_wdata     <= '0;
                        r_wstrb     <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef AXI4L_MASTER_TIMEOUT_EN
            // Watchdog overrides whatever the FSM chose this cycle.
            r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
            if (w_expire) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_write   <= r_write;
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b11;
                r_rsp_timeout <= 1'b1;
                r_state       <= RESP;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_timeout <= 1'b0;
            end
`endif
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
endmodule

// File: tb/tb_axi4lite_master_bfm.sv
// Self-checking bench for axi4lite_master_bfm: behavioural slave with programmable delays plus a
// reference memory model; the watchdog scenario runs only when AXI4L_MASTER_TIMEOUT_EN is defined.
module tb_axi4lite_master_bfm;
    localparam int TO_CYCLES = 16;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          start;
    } rsp_t;

    logic        clk, s_axi_areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

    int checks = 0, failures = 0, cyc = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic        aw_seen = 0, w_seen = 0, pend_b = 0, pend_r = 0, prev_rsp = 0;
    logic [4:0]  last_awaddr;
    logic [31:0] last_wdata, r_data;
    logic [3:0]  last_wstrb;
    int          rsp_start = 0;
    logic [31:0] slave_mem [8];
    logic [31:0] ref_mem [8];
    rsp_t rsp_q[$];
    int   acc_q[$];

    axi4lite_master_bfm #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .s_axi_aclk(clk), .s_axi_areset(s_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Rising-edge observer: handshakes, slave memory updates, and response capture.
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            cyc++;
            if (s_axi_areset) begin
                aw_seen = 0; w_seen = 0; pend_b = 0; pend_r = 0; prev_rsp = 0;
            end else begin
                if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
                if (m_axi_awvalid && m_axi_awready) begin aw_seen = 1; aw_hs++; last_awaddr = m_axi_awaddr; end
                if (m_axi_wvalid && m_axi_wready) begin w_seen = 1; w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb; end
                if (aw_seen && w_seen) begin
                    for (int b = 0; b < 4; b++)
                        if (last_wstrb[b]) slave_mem[last_awaddr[4:2]][8*b +: 8] = last_wdata[8*b +: 8];
                    aw_seen = 0; w_seen = 0; pend_b = 1; b_wait = 0;
                end
                if (m_axi_bvalid && m_axi_bready) pend_b = 0;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs++; pend_r = 1; r_wait = 0; r_data = slave_mem[m_axi_araddr[4:2]];
                end
                if (m_axi_rvalid && m_axi_rready) pend_r = 0;
                if (rsp_valid && !prev_rsp) rsp_start = cyc;
                if (rsp_valid && rsp_ready) begin
                    r.wr = rsp_write; r.rdata = rsp_rdata; r.resp = rsp_resp; r.to = rsp_timeout; r.start = rsp_start;
                    rsp_q.push_back(r);
                end
                prev_rsp = rsp_valid && !rsp_ready;
            end
        end
    end

    // Falling-edge slave driver: each ready/valid rises after its programmed number of waiting cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_dly); if (!m_axi_awready) aw_wait++; end
            else begin m_axi_awready = 0; aw_wait = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_dly); if (!m_axi_wready) w_wait++; end
            else begin m_axi_wready = 0; w_wait = 0; end
            if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_dly); if (!m_axi_arready) ar_wait++; end
            else begin m_axi_arready = 0; ar_wait = 0; end
            if (pend_b && b_wait >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; end
            else begin m_axi_bvalid = 0; m_axi_bresp = 2'($urandom); if (pend_b) b_wait++; end
            if (pend_r && r_wait >= r_dly) begin m_axi_rvalid = 1; m_axi_rdata = r_data; m_axi_rresp = cfg_rresp; end
            else begin m_axi_rvalid = 0; m_axi_rdata = $urandom; m_axi_rresp = 2'($urandom); if (pend_r) r_wait++; end
        end
    end

    function automatic void ref_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a[4:2]] = (ref_mem[a[4:2]] & ~m) | (d & m);
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!cmd_ready) begin
            $display("FAIL cmd_accept: cmd_ready stayed %b for %0d cycles, required 1", cmd_ready, n); failures++;
            cmd_valid = 0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 0;
        end
    endtask

    task automatic wait_rsp(output rsp_t r, output int acc);
        int n = 0;
        while (rsp_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (rsp_q.size() == 0) begin
            $display("FAIL rsp_wait: no response after %0d cycles, required one", n); failures++;
            r.wr = 'x; r.rdata = 'x; r.resp = 'x; r.to = 'x; r.start = -1000;
        end else r = rsp_q.pop_front();
        acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
    endtask

    task automatic test_reset();
        s_axi_areset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_write, rsp_timeout} !== 9'b0) begin
            $display("FAIL reset_ctrl: got %b, required 0", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_write, rsp_timeout}); failures++;
        end
        checks++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, rsp_rdata, rsp_resp} !== '0) begin
            $display("FAIL reset_data: addr/data/rsp not all zero (aw=%h ar=%h wd=%h ws=%h rd=%h)", m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, rsp_rdata); failures++;
        end
        s_axi_areset = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); failures++; end
    endtask

    task automatic test_write_stagger();
        rsp_t r; int acc, aw0, w0;
        aw_dly = 0; w_dly = 2; b_dly = 0; cfg_bresp = 2'b00;
        aw0 = aw_hs; w0 = w_hs;
        issue(1, 5'h08, 32'hDEADBEEF, 4'hF);
        ref_write(5'h08, 32'hDEADBEEF, 4'hF);
        wait_rsp(r, acc);
        checks++; if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin $display("FAIL wr_hs_count: aw=%0d w=%0d, required 1 and 1", aw_hs - aw0, w_hs - w0); failures++; end
        checks++; if (last_awaddr !== 5'h08) begin $display("FAIL wr_awaddr: got %h, required 08", last_awaddr); failures++; end
        checks++; if (last_wdata !== 32'hDEADBEEF || last_wstrb !== 4'hF) begin $display("FAIL wr_wdata: got %h/%h, required deadbeef/f", last_wdata, last_wstrb); failures++; end
        checks++; if (r.wr !== 1'b1 || r.resp !== 2'b00 || r.rdata !== 32'h0 || r.to !== 1'b0) begin
            $display("FAIL wr_rsp: got w=%b resp=%b rdata=%h to=%b, required 1/00/0/0", r.wr, r.resp, r.rdata, r.to); failures++; end
        checks++; if (r.start - acc != 5) begin $display("FAIL wr_latency: got %0d, required 5", r.start - acc); failures++; end
        w_dly = 0;
    endtask

    task automatic test_read_delay();
        rsp_t r; int acc;
        ar_dly = 0; r_dly = 2; cfg_rresp = 2'b00;
        issue(0, 5'h10, 32'h0, 4'h0);
        wait_rsp(r, acc);
        checks++; if (r.rdata !== ref_mem[4] || r.resp !== 2'b00 || r.wr !== 1'b0) begin
            $display("FAIL rd_rsp: got rdata=%h resp=%b w=%b, required %h/00/0", r.rdata, r.resp, r.wr, ref_mem[4]); failures++; end
        checks++; if (r.start - acc != 5) begin $display("FAIL rd_latency: got %0d, required 5", r.start - acc); failures++; end
        r_dly = 0;
    endtask

    task automatic test_back_to_back();
        rsp_t r1, r2; int a1, a2;
        issue(1, 5'h04, 32'hA5A5A5A5, 4'hF);
        ref_write(5'h04, 32'hA5A5A5A5, 4'hF);
        issue(0, 5'h04, 32'h0, 4'h0);
        wait_rsp(r1, a1);
        wait_rsp(r2, a2);
        checks++; if (a2 - a1 != 4) begin $display("FAIL b2b_spacing: got %0d cycles, required 4", a2 - a1); failures++; end
        checks++; if (r1.wr !== 1'b1 || r2.wr !== 1'b0) begin $display("FAIL b2b_order: got w=%b,%b required 1,0", r1.wr, r2.wr); failures++; end
        checks++; if (r2.rdata !== ref_mem[1]) begin $display("FAIL b2b_readback: got %h, required %h", r2.rdata, ref_mem[1]); failures++; end
    endtask

    task automatic test_rsp_hold();
        rsp_t r; int acc, n = 0;
        rsp_ready = 0; cfg_rresp = 2'b10;
        issue(0, 5'h00, 32'h0, 4'h0);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({rsp_valid, rsp_write, rsp_timeout, cmd_ready} !== 4'b1000 || rsp_rdata !== ref_mem[0] || rsp_resp !== 2'b10) begin
                $display("FAIL hold_stable[%0d]: got v/w/to/cr=%b rdata=%h resp=%b, required 1000/%h/10", k,
                         {rsp_valid, rsp_write, rsp_timeout, cmd_ready}, rsp_rdata, rsp_resp, ref_mem[0]); failures++;
            end
            if (k < 5) @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL hold_release: got cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid); failures++; end
        wait_rsp(r, acc);
        cfg_rresp = 2'b00;
    endtask

    task automatic test_reset_midflight();
        rsp_t r; int acc, ar0;
        w_dly = 1000;
        issue(1, 5'h0C, 32'h12345678, 4'hF);
        repeat (2) @(negedge clk);
        checks++; if (m_axi_wvalid !== 1'b1) begin $display("FAIL midrst_pending: wvalid=%b, required 1", m_axi_wvalid); failures++; end
        s_axi_areset = 1;
        @(negedge clk);
        s_axi_areset = 0;
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready} !== 7'b0) begin
            $display("FAIL midrst_outputs: got %b, required 0", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready}); failures++; end
        w_dly = 0;
        acc_q.delete();
        repeat (6) @(negedge clk);
        checks++; if (rsp_q.size() != 0 || rsp_valid !== 1'b0) begin $display("FAIL midrst_no_rsp: %0d responses seen, required 0", rsp_q.size()); failures++; end
        ar0 = ar_hs;
        issue(0, 5'h10, 32'h0, 4'h0);
        wait_rsp(r, acc);
        checks++; if (r.rdata !== ref_mem[4] || ar_hs - ar0 != 1) begin
            $display("FAIL midrst_recover: got rdata=%h ar_hs=%0d, required %h/1", r.rdata, ar_hs - ar0, ref_mem[4]); failures++; end
    endtask

    task automatic test_random();
        rsp_t r; int acc, aw0, w0, ar0, exp_lat;
        logic w; logic [4:0] a; logic [31:0] d, exp_rd; logic [3:0] s;
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom); a = {3'($urandom), 2'b00}; d = $urandom; s = 4'($urandom);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom);
            aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
            exp_lat = w ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
            exp_rd  = w ? 32'h0 : ref_mem[a[4:2]];
            if (w) ref_write(a, d, s);
            issue(w, a, d, s);
            wait_rsp(r, acc);
            checks++;
            if (r.wr !== w || r.rdata !== exp_rd || r.resp !== (w ? cfg_bresp : cfg_rresp) || r.to !== 1'b0) begin
                $display("FAIL rand_rsp[%0d]: got w=%b rdata=%h resp=%b to=%b, required %b/%h/%b/0", i, r.wr, r.rdata, r.resp, r.to,
                         w, exp_rd, w ? cfg_bresp : cfg_rresp); failures++; end
            checks++;
            if (r.start - acc != exp_lat) begin $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, r.start - acc, exp_lat); failures++; end
            checks++;
            if (w ? (aw_hs - aw0 != 1 || w_hs - w0 != 1 || ar_hs != ar0 || last_awaddr !== a || last_wdata !== d || last_wstrb !== s)
                  : (ar_hs - ar0 != 1 || aw_hs != aw0 || w_hs != w0)) begin
                $display("FAIL rand_channel[%0d]: hs aw/w/ar=%0d/%0d/%0d awaddr=%h wdata=%h wstrb=%h, cmd w=%b addr=%h data=%h strb=%h", i,
                         aw_hs - aw0, w_hs - w0, ar_hs - ar0, last_awaddr, last_wdata, last_wstrb, w, a, d, s); failures++; end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; cfg_bresp = 0; cfg_rresp = 0;
    endtask

`ifdef AXI4L_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        rsp_t r; int acc, n = 0, hi = 0;
        ar_dly = 100000;
        issue(0, 5'h14, 32'h0, 4'h0);
        while (!rsp_valid && n < 100) begin if (m_axi_arvalid) hi++; @(negedge clk); n++; end
        checks++; if (hi != TO_CYCLES) begin $display("FAIL to_arvalid_cycles: got %0d, required %0d", hi, TO_CYCLES); failures++; end
        wait_rsp(r, acc);
        checks++; if (r.resp !== 2'b11 || r.to !== 1'b1 || r.rdata !== 32'h0 || r.wr !== 1'b0) begin
            $display("FAIL to_rsp: got resp=%b to=%b rdata=%h w=%b, required 11/1/0/0", r.resp, r.to, r.rdata, r.wr); failures++; end
        checks++; if (r.start - acc != TO_CYCLES + 1) begin $display("FAIL to_latency: got %0d, required %0d", r.start - acc, TO_CYCLES + 1); failures++; end
        ar_dly = 0;
    endtask
`endif

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
        m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        for (int i = 0; i < 8; i++) begin slave_mem[i] = 32'h1000_0000 + i * 32'h0101_0101; ref_mem[i] = slave_mem[i]; end
        slave_mem[4] = 32'h0000_0005; ref_mem[4] = 32'h0000_0005;
        test_reset();
        test_write_stagger();
        test_read_delay();
        test_back_to_back();
        test_rsp_hold();
        test_reset_midflight();
        test_random();
`ifdef AXI4L_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
